// File: rtl/semaforo_pkg.sv
// Shared types and constants for the semaforo two-way traffic-light controller.
package semaforo_pkg;

   typedef enum logic [1:0] {AG, AY, BG, BY} state_t;

   localparam logic [2:0] LUZ_VERDE    = 3'b001;
   localparam logic [2:0] LUZ_AMARELO  = 3'b010;
   localparam logic [2:0] LUZ_VERMELHO = 3'b100;

   localparam int CNT_W = 8;

   // A programmed duration of 0 cycles is treated as 1 cycle.
   function automatic logic [CNT_W-1:0] eff_time(input int unsigned t);
      return (t == 0) ? CNT_W'(1) : CNT_W'(t);
   endfunction

endpackage

// File: rtl/semaforo_timer.sv
// Saturating dwell counter shared by all light phases; done flags the last cycle
// of the selected target duration.
module semaforo_timer
   import semaforo_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic [CNT_W-1:0] target,
   output logic [CNT_W-1:0] cnt,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] target_eff;

   always_comb begin
      // NOTE: default first so every path assigns cnt_d and no latch is inferred.
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (cnt_q != '1)
         cnt_d = cnt_q + CNT_W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   always_comb begin
      target_eff = (target == '0) ? CNT_W'(1) : target;
      done       = (cnt_q == target_eff - CNT_W'(1));
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/semaforo.sv
// Two-way traffic-light Moore FSM: road A rests green, button bt grants road B one
// timed cycle. Define SEMAFORO_BT_MEMORY_EN to remember presses made outside AG.
module semaforo
   import semaforo_pkg::*;
#(
   parameter int unsigned T_VERDE    = 1,
   parameter int unsigned T_AMARELO  = 3,
   parameter int unsigned T_VERMELHO = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bt,
   output logic [2:0] A,
   output logic [2:0] B
);

   localparam logic [CNT_W-1:0] TV = eff_time(T_VERDE);
   localparam logic [CNT_W-1:0] TY = eff_time(T_AMARELO);
   localparam logic [CNT_W-1:0] TR = eff_time(T_VERMELHO);

   state_t           state_q, state_d;
   logic             req_q, req_d;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] target;
   logic             done;
   logic             clear;
   logic             verde_ok;

   semaforo_timer u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear),
      .target (target),
      .cnt    (cnt),
      .done   (done)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= AG;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
      end
   end

   always_comb begin
      target = TV;
      case (state_q)
         AY, BY:  target = TY;
         BG:      target = TR;
         default: target = TV;
      endcase
   end

   assign verde_ok = (cnt >= TV - CNT_W'(1));

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      case (state_q)
         AG: begin
            if (verde_ok && (bt || req_q))
               state_d = AY;
            else if (bt)
               req_d = 1'b1;
         end
         AY:      if (done) state_d = BG;
         BG:      if (done) state_d = BY;
         BY:      if (done) state_d = AG;
         default: state_d = AG;
      endcase
`ifdef SEMAFORO_BT_MEMORY_EN
      if (state_q != AG && bt)
         req_d = 1'b1;
`endif
      // A request is consumed by the move into yellow.
      if (state_q == AG && state_d == AY)
         req_d = 1'b0;
   end

   assign clear = (state_d != state_q);

   always_comb begin
      A = LUZ_VERDE;
      B = LUZ_VERMELHO;
      case (state_q)
         AY: begin A = LUZ_AMARELO;  B = LUZ_VERMELHO; end
         BG: begin A = LUZ_VERMELHO; B = LUZ_VERDE;    end
         BY: begin A = LUZ_VERMELHO; B = LUZ_AMARELO;  end
         default: begin A = LUZ_VERDE; B = LUZ_VERMELHO; end
      endcase
   end

endmodule

// File: tb/tb_semaforo.sv
// Bench for semaforo: two instances (T_VERDE=1 and T_VERDE=4) driven by one button,
// compared each cycle against a phase/elapsed-time reference model.
module tb_semaforo;

`ifdef SEMAFORO_BT_MEMORY_EN
   localparam bit MEM = 1'b1;
`else
   localparam bit MEM = 1'b0;
`endif
   localparam int TY = 3;
   localparam int TR = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bt  = 1'b0;
   logic [2:0] a1, b1, a4, b4;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int ph;    // 0 A green, 1 A yellow, 2 B green, 3 B yellow
      int el;    // cycles completed in current phase
      bit pend;  // outstanding request
   } mdl_t;

   mdl_t m1, m4;

   semaforo dut1 (.clk(clk), .rst(rst), .bt(bt), .A(a1), .B(b1));
   semaforo #(.T_VERDE(4)) dut4 (.clk(clk), .rst(rst), .bt(bt), .A(a4), .B(b4));

   always #5 clk = ~clk;

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m.ph = 0; m.el = 0; m.pend = 1'b0;
      return m;
   endfunction

   function automatic mdl_t mdl_next(mdl_t m, bit b, int tv);
      int dur [4];
      dur = '{tv, TY, TR, TY};
      if (m.el < 1000) m.el++;
      if (m.ph == 0) begin
         if (m.el >= tv && (b || m.pend)) begin
            m.ph = 1; m.el = 0; m.pend = 1'b0;
         end else if (b) begin
            m.pend = 1'b1;
         end
      end else begin
         if (MEM && b) m.pend = 1'b1;
         if (m.el == dur[m.ph]) begin
            m.ph = (m.ph + 1) % 4; m.el = 0;
         end
      end
      return m;
   endfunction

   function automatic logic [5:0] lamps(int ph);
      case (ph)
         1:       return {3'b010, 3'b100};
         2:       return {3'b100, 3'b001};
         3:       return {3'b100, 3'b010};
         default: return {3'b001, 3'b100};
      endcase
   endfunction

   task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic compare_all(input string tag);
      logic [5:0] e1, e4;
      e1 = lamps(m1.ph);
      e4 = lamps(m4.ph);
      check({tag, "_A1"}, a1, e1[5:3]);
      check({tag, "_B1"}, b1, e1[2:0]);
      check({tag, "_A4"}, a4, e4[5:3]);
      check({tag, "_B4"}, b4, e4[2:0]);
      check({tag, "_mutex1"}, (a1 != 3'b100 && b1 != 3'b100) ? 3'b111 : 3'b000, 3'b000);
      check({tag, "_mutex4"}, (a4 != 3'b100 && b4 != 3'b100) ? 3'b111 : 3'b000, 3'b000);
   endtask

   // Called at a falling edge; returns at a falling edge.
   task automatic step(input bit b, input string tag);
      bt = b;
      @(posedge clk);
      m1 = mdl_next(m1, b, 1);
      m4 = mdl_next(m4, b, 4);
      @(negedge clk);
      compare_all(tag);
   endtask

   // Called at a falling edge; pulls reset between edges and holds it over one edge.
   task automatic reset_async(input string tag);
      #2 rst = 1'b0;
      #1;
      check({tag, "_imm_A1"}, a1, 3'b001);
      check({tag, "_imm_B1"}, b1, 3'b100);
      check({tag, "_imm_A4"}, a4, 3'b001);
      check({tag, "_imm_B4"}, b4, 3'b100);
      m1 = mdl_reset();
      m4 = mdl_reset();
      bt = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_A1"}, a1, 3'b001);
      check({tag, "_hold_B4"}, b4, 3'b100);
      bt  = 1'b0;
      rst = 1'b1;
   endtask

   initial begin
      logic [5:0] ep;
      int         r, ph;

      m1 = mdl_reset();
      m4 = mdl_reset();

      // Reset values before any clock edge, then held across an edge with bt high.
      #1 rst = 1'b0;
      #1;
      check("rst_A1", a1, 3'b001);
      check("rst_B1", b1, 3'b100);
      check("rst_A4", a4, 3'b001);
      check("rst_B4", b4, 3'b100);
      bt = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_hold_A1", a1, 3'b001);
      check("rst_hold_B1", b1, 3'b100);
      bt  = 1'b0;
      rst = 1'b1;

      // Single press at the first edge; dut4 latches it until its minimum green.
      step(1'b1, "press1");
      check("press_A1_yellow", a1, 3'b010);
      check("press_A4_green", a4, 3'b001);
      step(1'b0, "press2");
      step(1'b0, "press3");
      check("mingreen_A4_still_green", a4, 3'b001);
      step(1'b0, "press4");
      check("mingreen_A4_yellow", a4, 3'b010);
      check("press_B1_green", b1, 3'b001);
      for (int i = 5; i <= 22; i++) step(1'b0, "press_tail");
      check("press_rest_A1", a1, 3'b001);
      check("press_rest_A4", a4, 3'b001);

      // Reset in the middle of A yellow.
      step(1'b1, "midAY_press");
      check("midAY_A1", a1, 3'b010);
      reset_async("midAY");

      // Press during B green: discarded or remembered depending on build.
      for (int i = 0; i < 3; i++) step(1'b0, "late_idle");
      step(1'b1, "late_go");
      for (int i = 2; i <= 4; i++) step(1'b0, "late_ay");
      step(1'b1, "late_bg_press");
      check("late_bg_B1", b1, 3'b001);
      for (int i = 6; i <= 9; i++) step(1'b0, "late_by");
      check("late_back_A1", a1, 3'b001);
      step(1'b0, "late_after");
      check("late_after_A1", a1, MEM ? 3'b010 : 3'b001);
      for (int i = 11; i <= 22; i++) step(1'b0, "late_tail");
      check("late_end_A1", a1, 3'b001);
      check("late_end_A4", a4, 3'b001);

      // Button held for 30 cycles: period 9 on the default instance.
      reset_async("cont");
      for (int k = 1; k <= 30; k++) begin
         step(1'b1, "cont");
         r  = (k - 1) % 9;
         ph = (r < 3) ? 1 : (r < 5) ? 2 : (r < 8) ? 3 : 0;
         ep = lamps(ph);
         check("cont_period_A1", a1, ep[5:3]);
         check("cont_period_B1", b1, ep[2:0]);
      end

      // Random button traffic with occasional asynchronous resets.
      reset_async("rand_start");
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 59) == 0)
            reset_async("rand_rst");
         else
            step($urandom_range(0, 3) == 0, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
